// File: rtl/raptor64_target_reg_sequencer_if.sv
// Bus bundle for raptor64_target_reg_sequencer: decode-side target
// information and pipeline advance strobes in, X/W-stage targets and the
// decode stall out. The master modport belongs to the pipeline controller
// and the slave modport to the sequencer.
interface raptor64_target_reg_sequencer_if #(
  parameter int NREGS = 32,
  parameter int CTXW  = 4
);
  localparam int RW = $clog2(NREGS);
  localparam int TW = CTXW + RW;

  // pipeline advance strobes
  logic             advanceR;
  logic             advanceX;
  logic             advanceW;

  // decode-stage target description
  logic             dWrite;
  logic [RW-1:0]    dRt;
  logic             dMulti;
  logic [NREGS-1:0] dMask;
  logic [CTXW-1:0]  dAXC;

  // X/W-stage targets and decode hold
  logic [TW-1:0]    xRt;
  logic [RW-1:0]    xOffs;
  logic             xLast;
  logic [TW-1:0]    wRt;
  logic             stallR;

  modport master (
    output advanceR, advanceX, advanceW,
    output dWrite, dRt, dMulti, dMask, dAXC,
    input  xRt, xOffs, xLast, wRt, stallR
  );

  modport slave (
    input  advanceR, advanceX, advanceW,
    input  dWrite, dRt, dMulti, dMask, dAXC,
    output xRt, xOffs, xLast, wRt, stallR
  );
endinterface

// File: rtl/raptor64_target_reg_sequencer.sv
// raptor64_target_reg_sequencer
// Registers the destination {context,reg} of each decoded instruction into
// the X and W stages. Load-multiple masks are expanded into one target per
// X-stage advance, with decode held (stallR) while the expansion runs.
// Build option: define RAPTOR64_LM_DESCEND_EN to expand LM masks from the
// highest register downward; otherwise expansion runs from r1 upward.
module raptor64_target_reg_sequencer #(
  parameter int NREGS = 32,
  parameter int CTXW  = 4
) (
  input logic clk,
  input logic rst,
  raptor64_target_reg_sequencer_if.slave bus
);
  localparam int RW = $clog2(NREGS);
  localparam int TW = CTXW + RW;

  typedef enum logic {
    IDLE = 1'b0,
    SEQ  = 1'b1
  } state_t;

  state_t           state;
  state_t           stateNext;

  // registers still to be issued for the LM in flight, and its context
  logic [NREGS-1:0] rem;
  logic [NREGS-1:0] remNext;
  logic [CTXW-1:0]  ctx;
  logic [CTXW-1:0]  ctxNext;

  // X/W-stage output registers
  logic [TW-1:0]    xRtQ;
  logic [TW-1:0]    xRtNext;
  logic [RW-1:0]    xOffsQ;
  logic [RW-1:0]    xOffsNext;
  logic             xLastQ;
  logic             xLastNext;
  logic [TW-1:0]    wRtQ;
  logic [TW-1:0]    wRtNext;

  // shared register picker: fed from the new LM mask in IDLE and from the
  // remaining mask in SEQ, so one encoder serves both start and continue
  logic [NREGS-1:0] lmMask;
  logic [NREGS-1:0] pickSrc;
  logic [RW-1:0]    pick;
  logic [NREGS-1:0] pickBit;

  // Select the next register to issue from a mask. The loop visits bits so
  // that the preferred bit is written last and therefore wins.
  function automatic logic [RW-1:0] firstSet(input logic [NREGS-1:0] v);
    logic [RW-1:0] p;
    p = '0;
`ifdef RAPTOR64_LM_DESCEND_EN
    for (int unsigned i = 0; i < NREGS; i++) begin
      if (v[i]) p = RW'(i);
    end
`else
    for (int unsigned i = 0; i < NREGS; i++) begin
      if (v[NREGS-1-i]) p = RW'(NREGS-1-i);
    end
`endif
    return p;
  endfunction

  // Picker inputs: r0 is never an LM target, so bit0 is stripped up front.
  always_comb begin
    lmMask  = {bus.dMask[NREGS-1:1], 1'b0};
    pickSrc = (state == SEQ) ? rem : lmMask;
    pick    = firstSet(pickSrc);
    pickBit = {{(NREGS-1){1'b0}}, 1'b1} << pick;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  // Next-state and next X/W-stage values.
  always_comb begin
    stateNext = state;
    remNext   = rem;
    ctxNext   = ctx;
    xRtNext   = xRtQ;
    xOffsNext = xOffsQ;
    xLastNext = xLastQ;

    unique case (state)
      IDLE: begin
        if (bus.advanceR) begin
          xOffsNext = '0;
          if (!bus.dMulti) begin
            xRtNext   = (bus.dWrite && bus.dRt != '0) ? {bus.dAXC, bus.dRt} : '0;
            xLastNext = 1'b1;
          end else if (lmMask == '0) begin
            xRtNext   = '0;
            xLastNext = 1'b1;
          end else begin
            xRtNext = {bus.dAXC, pick};
            remNext = lmMask & ~pickBit;
            ctxNext = bus.dAXC;
            if (remNext != '0) begin
              stateNext = SEQ;
              xLastNext = 1'b0;
            end else begin
              xLastNext = 1'b1;
            end
          end
        end else if (bus.advanceX) begin
          xRtNext   = '0;
          xOffsNext = '0;
          xLastNext = 1'b0;
        end
      end

      SEQ: begin
        if (bus.advanceX) begin
          xRtNext   = {ctx, pick};
          xOffsNext = xOffsQ + 1'b1;
          remNext   = rem & ~pickBit;
          if (remNext == '0) begin
            xLastNext = 1'b1;
            stateNext = IDLE;
          end else begin
            xLastNext = 1'b0;
          end
        end
      end

      default: begin
        stateNext = IDLE;
      end
    endcase

    if (bus.advanceX)      wRtNext = xRtQ;
    else if (bus.advanceW) wRtNext = '0;
    else                   wRtNext = wRtQ;
  end

  // Datapath registers; reset abandons any LM expansion in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      rem    <= '0;
      ctx    <= '0;
      xRtQ   <= '0;
      xOffsQ <= '0;
      xLastQ <= 1'b0;
      wRtQ   <= '0;
    end else begin
      rem    <= remNext;
      ctx    <= ctxNext;
      xRtQ   <= xRtNext;
      xOffsQ <= xOffsNext;
      xLastQ <= xLastNext;
      wRtQ   <= wRtNext;
    end
  end

  // Output drive; stallR is decoded straight from the state register.
  always_comb begin
    bus.xRt    = xRtQ;
    bus.xOffs  = xOffsQ;
    bus.xLast  = xLastQ;
    bus.wRt    = wRtQ;
    bus.stallR = (state == SEQ);
  end

endmodule
